// File: rtl/program_sequencer_stk_pkg.sv
// Shared types and helpers for the program sequencer slice.
package ps_pkg;

    localparam int unsigned TGT_MAX_W = 32;

    // Source selected for the next fetch address, listed in priority order.
    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_RET,
        SRC_CALL,
        SRC_IR,
        SRC_JMP,
        SRC_JNZ,
        SRC_HOLD,
        SRC_INC
    } next_src_t;

    // Coarse jump target: jmp_addr placed in the upper bits, zeros below.
    function automatic logic [TGT_MAX_W-1:0] jump_target(
        input logic [TGT_MAX_W-1:0] coarse,
        input int unsigned          addr_w,
        input int unsigned          jmp_w
    );
        return coarse << (addr_w - jmp_w);
    endfunction

endpackage

// File: rtl/program_sequencer_stk_if.sv
// Decoder <-> sequencer bus: control requests in, fetch address and stack status out.
interface program_sequencer_stk_if #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned JMP_W       = 4,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic              sync_reset;
    logic [JMP_W-1:0]  jmp_addr;
    logic [ADDR_W-1:0] ir;
    logic              jmp;
    logic              jmp_nz;
    logic              dont_jmp;
    logic              call;
    logic              ret;
    logic              hold;
    logic [ADDR_W-1:0] pm_addr;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   stack_level;
    logic              stack_overflow;
    logic              stack_underflow;
    logic [ADDR_W-1:0] from_PS;

    modport master (
        output sync_reset, jmp_addr, ir, jmp, jmp_nz, dont_jmp, call, ret, hold,
        input  pm_addr, pc, stack_level, stack_overflow, stack_underflow, from_PS
    );

    modport slave (
        input  sync_reset, jmp_addr, ir, jmp, jmp_nz, dont_jmp, call, ret, hold,
        output pm_addr, pc, stack_level, stack_overflow, stack_underflow, from_PS
    );

endinterface

// File: rtl/program_sequencer_stk_stack.sv
// Return-address stack; push/pop requests are ignored when full/empty.
module ps_return_stack #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 8,
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [LW-1:0] lvl_q;

    assign level = lvl_q;
    assign full  = (lvl_q == LW'(DEPTH));
    assign empty = (lvl_q == '0);

    // Entry storage and occupancy; clear only drops the level, contents stay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            lvl_q <= '0;
        end else if (clear) begin
            lvl_q <= '0;
        end else if (push && !full) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (LW'(i) == lvl_q) mem[i] <= din;
            end
            lvl_q <= lvl_q + LW'(1);
        end else if (pop && !empty) begin
            lvl_q <= lvl_q - LW'(1);
        end
    end

    // Top-of-stack view, zero when empty.
    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (LW'(i + 1) == lvl_q) top = mem[i];
        end
    end

endmodule

// File: rtl/program_sequencer_stk.sv
// Program sequencer: prioritised next-address mux, pc register, call/return stack.
module program_sequencer_stk
    import ps_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned JMP_W       = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    program_sequencer_stk_if.slave bus
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    next_src_t         src;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] nxt;
    logic              ovf_q;
    logic              unf_q;
    logic [ADDR_W-1:0] stk_top;
    logic [SP_W-1:0]   stk_level;
    logic              stk_full;
    logic              stk_empty;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign jmp_tgt = ADDR_W'(jump_target(TGT_MAX_W'(bus.jmp_addr), ADDR_W, JMP_W));

    // Pick the single highest-priority request; only it has side effects.
    always_comb begin
        src = SRC_INC;
        if (bus.sync_reset)                    src = SRC_RESET;
        else if (bus.ret)                      src = SRC_RET;
        else if (bus.call)                     src = SRC_CALL;
        else if (bus.jmp && bus.jmp_nz)        src = SRC_IR;
        else if (bus.jmp)                      src = SRC_JMP;
        else if (bus.jmp_nz && !bus.dont_jmp)  src = SRC_JNZ;
        else if (bus.hold)                     src = SRC_HOLD;
    end

    // Next fetch address for the selected source.
    always_comb begin
        case (src)
            SRC_RESET: nxt = '0;
            SRC_RET:   nxt = stk_empty ? pc_inc : stk_top;
            SRC_CALL:  nxt = bus.ir;
            SRC_IR:    nxt = bus.ir;
            SRC_JMP:   nxt = jmp_tgt;
            SRC_JNZ:   nxt = jmp_tgt;
            SRC_HOLD:  nxt = pc_q;
            default:   nxt = pc_inc;
        endcase
    end

    ps_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (src == SRC_CALL),
        .pop     (src == SRC_RET),
        .clear   (src == SRC_RESET),
        .din     (pc_inc),
        .top     (stk_top),
        .level   (stk_level),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    // Program counter and sticky stack health flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q <= nxt;
            if (src == SRC_RESET) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (src == SRC_CALL && stk_full)  ovf_q <= 1'b1;
                if (src == SRC_RET  && stk_empty) unf_q <= 1'b1;
            end
        end
    end

    assign bus.pm_addr         = reset_n ? nxt : '0;
    assign bus.pc              = pc_q;
    assign bus.stack_level     = stk_level;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
    assign bus.from_PS         = stk_top;

endmodule

// File: tb/tb_program_sequencer_stk.sv
// Bench: two sequencers (stack depth 4 and 1) on shared stimulus, against a behavioural model.
module tb_program_sequencer_stk;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sync_reset, jmp, jmp_nz, dont_jmp, call, ret, hold;
    logic [3:0] jmp_addr;
    logic [7:0] ir;

    int total = 0;
    int bad   = 0;

    // Model state: index 0 = depth-4 instance, index 1 = depth-1 instance.
    logic [7:0] m_pc  [2];
    int         m_lvl [2];
    logic       m_ovf [2];
    logic       m_unf [2];
    logic [7:0] m_stk [2][4];

    program_sequencer_stk_if #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(4)) bus4 ();
    program_sequencer_stk_if #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(1)) bus1 ();

    assign bus4.sync_reset = sync_reset;  assign bus1.sync_reset = sync_reset;
    assign bus4.jmp_addr   = jmp_addr;    assign bus1.jmp_addr   = jmp_addr;
    assign bus4.ir         = ir;          assign bus1.ir         = ir;
    assign bus4.jmp        = jmp;         assign bus1.jmp        = jmp;
    assign bus4.jmp_nz     = jmp_nz;      assign bus1.jmp_nz     = jmp_nz;
    assign bus4.dont_jmp   = dont_jmp;    assign bus1.dont_jmp   = dont_jmp;
    assign bus4.call       = call;        assign bus1.call       = call;
    assign bus4.ret        = ret;         assign bus1.ret        = ret;
    assign bus4.hold       = hold;        assign bus1.hold       = hold;

    program_sequencer_stk #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );
    program_sequencer_stk #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] exp_pm(input int k);
        if (!reset_n)   return 8'h00;
        if (sync_reset) return 8'h00;
        if (ret)        return (m_lvl[k] > 0) ? m_stk[k][m_lvl[k] - 1] : 8'(m_pc[k] + 1);
        if (call)       return ir;
        if (jmp && jmp_nz) return ir;
        if (jmp || (jmp_nz && !dont_jmp)) return 8'(int'(jmp_addr) * 16);
        if (hold)       return m_pc[k];
        return 8'(m_pc[k] + 1);
    endfunction

    function automatic logic [7:0] exp_from(input int k);
        return (m_lvl[k] > 0) ? m_stk[k][m_lvl[k] - 1] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 8'h00; m_lvl[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
            for (int j = 0; j < 4; j++) m_stk[k][j] = 8'h00;
        end
    endtask

    task automatic model_edge();
        logic [7:0] nxt;
        if (!reset_n) return;
        for (int k = 0; k < 2; k++) begin
            nxt = exp_pm(k);
            if (sync_reset) begin
                m_lvl[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
            end else if (ret) begin
                if (m_lvl[k] > 0) m_lvl[k] = m_lvl[k] - 1;
                else              m_unf[k] = 1'b1;
            end else if (call) begin
                if (m_lvl[k] < dep(k)) begin
                    m_stk[k][m_lvl[k]] = 8'(m_pc[k] + 1);
                    m_lvl[k] = m_lvl[k] + 1;
                end else begin
                    m_ovf[k] = 1'b1;
                end
            end
            m_pc[k] = nxt;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string nm, input int k, input logic [7:0] pm,
                            input logic [7:0] pc, input int lvl, input logic ovf,
                            input logic unf, input logic [7:0] fps);
        chk({nm, ".pm_addr"},   32'(pm),  32'(exp_pm(k)));
        chk({nm, ".pc"},        32'(pc),  32'(m_pc[k]));
        chk({nm, ".level"},     32'(lvl), 32'(m_lvl[k]));
        chk({nm, ".overflow"},  32'(ovf), 32'(m_ovf[k]));
        chk({nm, ".underflow"}, 32'(unf), 32'(m_unf[k]));
        chk({nm, ".from_PS"},   32'(fps), 32'(exp_from(k)));
    endtask

    // Every cycle, away from the active edge, compare both instances to the model.
    always @(negedge clk) begin
        cmp_inst("d4", 0, bus4.pm_addr, bus4.pc, int'(bus4.stack_level),
                 bus4.stack_overflow, bus4.stack_underflow, bus4.from_PS);
        cmp_inst("d1", 1, bus1.pm_addr, bus1.pc, int'(bus1.stack_level),
                 bus1.stack_overflow, bus1.stack_underflow, bus1.from_PS);
    end

    task automatic idle();
        sync_reset = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0; hold = 0;
        jmp_addr = 4'h0; ir = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset_pulse();
        #2 reset_n = 1'b0;
        #1 model_reset();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        ticks(2);
        chk("reset.pc", 32'(bus4.pc), 32'h00);
        chk("reset.pm_addr", 32'(bus4.pm_addr), 32'h00);
        reset_n = 1'b1;

        // Free-running increment with wrap.
        ticks(255);
        chk("inc.pc_ff", 32'(bus4.pc), 32'hFF);
        tick();
        chk("inc.wrap", 32'(bus4.pc), 32'h00);
        tick();
        chk("inc.after_wrap", 32'(bus4.pc), 32'h01);

        // Jump modes.
        sync_reset = 1; tick(); sync_reset = 0;
        ticks(5);
        chk("jmp.start", 32'(bus4.pc), 32'h05);
        jmp = 1; jmp_addr = 4'hA; tick();
        chk("jmp.coarse", 32'(bus4.pc), 32'hA0);
        jmp = 0; jmp_nz = 1; dont_jmp = 1; tick();
        chk("jnz.not_taken", 32'(bus4.pc), 32'hA1);
        dont_jmp = 0; jmp_addr = 4'h3; tick();
        chk("jnz.taken", 32'(bus4.pc), 32'h30);
        jmp = 1; ir = 8'h7E; tick();
        chk("jmp.absolute", 32'(bus4.pc), 32'h7E);
        idle();

        // Nested call/return.
        jmp = 1; jmp_addr = 4'h1; tick(); idle();
        chk("call.start", 32'(bus4.pc), 32'h10);
        call = 1; ir = 8'h40; tick(); idle();
        chk("call1.pc", 32'(bus4.pc), 32'h40);
        chk("call1.level", 32'(bus4.stack_level), 32'd1);
        chk("call1.from", 32'(bus4.from_PS), 32'h11);
        tick();
        call = 1; ir = 8'h80; tick(); idle();
        chk("call2.pc", 32'(bus4.pc), 32'h80);
        chk("call2.level", 32'(bus4.stack_level), 32'd2);
        chk("call2.from", 32'(bus4.from_PS), 32'h42);
        ticks(2);
        chk("call2.body", 32'(bus4.pc), 32'h82);
        ret = 1; tick();
        chk("ret1.pc", 32'(bus4.pc), 32'h42);
        chk("ret1.level", 32'(bus4.stack_level), 32'd1);
        chk("ret1.from", 32'(bus4.from_PS), 32'h11);
        tick(); idle();
        chk("ret2.pc", 32'(bus4.pc), 32'h11);
        chk("ret2.level", 32'(bus4.stack_level), 32'd0);
        chk("ret2.from", 32'(bus4.from_PS), 32'h00);
        chk("d1.call_overflow", 32'(bus1.stack_overflow), 32'd1);

        // Overflow then underflow on the depth-4 stack.
        sync_reset = 1; tick(); idle();
        for (int i = 0; i < 5; i++) begin
            call = 1; ir = 8'(8'h20 + 16 * i); tick();
        end
        idle();
        chk("ovf.level", 32'(bus4.stack_level), 32'd4);
        chk("ovf.flag", 32'(bus4.stack_overflow), 32'd1);
        chk("ovf.target", 32'(bus4.pc), 32'h60);
        ret = 1;
        tick(); chk("pop.41", 32'(bus4.pc), 32'h41);
        tick(); chk("pop.31", 32'(bus4.pc), 32'h31);
        tick(); chk("pop.21", 32'(bus4.pc), 32'h21);
        tick(); chk("pop.01", 32'(bus4.pc), 32'h01);
        chk("pop.no_unf", 32'(bus4.stack_underflow), 32'd0);
        tick(); chk("unf.pc", 32'(bus4.pc), 32'h02);
        chk("unf.flag", 32'(bus4.stack_underflow), 32'd1);
        idle(); tick();
        chk("unf.sticky", 32'(bus4.stack_underflow), 32'd1);
        chk("ovf.sticky", 32'(bus4.stack_overflow), 32'd1);
        sync_reset = 1; call = 1; ir = 8'hEE; tick(); idle();
        chk("sync.pc", 32'(bus4.pc), 32'h00);
        chk("sync.ovf", 32'(bus4.stack_overflow), 32'd0);
        chk("sync.unf", 32'(bus4.stack_underflow), 32'd0);
        chk("sync.level", 32'(bus4.stack_level), 32'd0);

        // Hold and priority.
        jmp = 1; jmp_addr = 4'h2; tick(); idle();
        ticks(2);
        hold = 1; ticks(3);
        chk("hold.pc", 32'(bus4.pc), 32'h22);
        jmp = 1; jmp_addr = 4'h1; tick(); idle();
        chk("hold_jmp.pc", 32'(bus4.pc), 32'h10);
        jmp = 1; jmp_addr = 4'h5; tick(); idle();
        ticks(4);
        call = 1; ir = 8'h90; tick(); idle();
        chk("pri.top", 32'(bus4.from_PS), 32'h55);
        call = 1; ret = 1; ir = 8'hC0; tick(); idle();
        chk("callret.pc", 32'(bus4.pc), 32'h55);
        chk("callret.level", 32'(bus4.stack_level), 32'd0);

        // Asynchronous reset between edges with three entries stacked.
        sync_reset = 1; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            call = 1; ir = 8'(8'h20 + 16 * i); tick();
        end
        idle();
        chk("areset.pre_level", 32'(bus4.stack_level), 32'd3);
        #2 reset_n = 1'b0;
        #1 model_reset();
        chk("areset.pc", 32'(bus4.pc), 32'h00);
        chk("areset.pm_addr", 32'(bus4.pm_addr), 32'h00);
        chk("areset.level", 32'(bus4.stack_level), 32'd0);
        chk("areset.ovf", 32'(bus4.stack_overflow), 32'd0);
        chk("areset.unf", 32'(bus4.stack_underflow), 32'd0);
        chk("areset.from", 32'(bus4.from_PS), 32'h00);
        tick();
        reset_n = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            sync_reset = ($urandom_range(0, 99) < 2);
            ret        = ($urandom_range(0, 99) < 15);
            call       = ($urandom_range(0, 99) < 18);
            jmp        = ($urandom_range(0, 99) < 10);
            jmp_nz     = ($urandom_range(0, 99) < 10);
            dont_jmp   = 1'($urandom_range(0, 1));
            hold       = ($urandom_range(0, 99) < 20);
            ir         = 8'($urandom_range(0, 255));
            jmp_addr   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
            else tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
